// File: rtl/hmac_seq_pkg.sv
// hmac_seq_pkg: shared types, constants and word-padding helper for the HMAC message sequencer
package hmac_seq_pkg;
  typedef enum logic [2:0] {IDLE, FILL, PAD, LEN, ISSUE, WAIT, DONE} state_e;
  localparam int BLOCK_W = 1024;
  localparam int CNT_W = 64;
  localparam int BLOCK_WORDS = 32;
  localparam int LEN_WORD = 28;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam int KEY_BLK_BITS = 1024;
  // Places the 0x80 pad byte right after the last valid byte of a partial word
  function automatic logic [31:0] pad_word(input logic [31:0] d, input logic [2:0] b);
    return (b > 3'd3) ? d
         : (d & ~(32'hFF << (8 * (3 - b)))) | ({24'h0, PAD_BYTE} << (8 * (3 - b)));
  endfunction
endpackage

// File: rtl/hmac_blk_buf.sv
// hmac_blk_buf: 32x32 block buffer with byte-masked word write, length-word write,
// synchronous clear and a flat read port (word 0 in the top bits).
module hmac_blk_buf
  import hmac_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr_i,
  input  logic               we_i,
  input  logic [4:0]         waddr_i,
  input  logic [31:0]        wdata_i,
  input  logic [3:0]         wmask_i,
  input  logic               len_we_i,
  input  logic [63:0]        len_i,
  output logic [BLOCK_W-1:0] rdata_o
);
  logic [31:0] mem_q [BLOCK_WORDS];
  logic [31:0] bmask;
  assign bmask = {{8{wmask_i[3]}}, {8{wmask_i[2]}}, {8{wmask_i[1]}}, {8{wmask_i[0]}}};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BLOCK_WORDS; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < BLOCK_WORDS; i++) mem_q[i] <= '0;
    end else begin
      if (we_i) mem_q[waddr_i] <= wdata_i & bmask;
      if (len_we_i) begin
        mem_q[BLOCK_WORDS-2] <= len_i[63:32];
        mem_q[BLOCK_WORDS-1] <= len_i[31:0];
      end
    end
  end
  for (genvar g = 0; g < BLOCK_WORDS; g++) begin : g_rd
    assign rdata_o[BLOCK_W-1-32*g -: 32] = mem_q[g];
  end
endmodule

// File: rtl/hmac_msg_sequencer.sv
// hmac_msg_sequencer: packs a 32-bit word stream into SHA-512-padded 1024-bit blocks,
// sequences them through the HMAC core and returns only the final tag.
module hmac_msg_sequencer
  import hmac_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               zeroize,
  input  logic               start,
  input  logic               mode,
  input  logic [511:0]       key,
  input  logic               msg_valid,
  output logic               msg_ready,
  input  logic [31:0]        msg_data,
  input  logic               msg_last,
  input  logic [2:0]         msg_bytes,
  output logic               busy,
  output logic [511:0]       tag,
  output logic               tag_valid,
  output logic               core_init,
  output logic               core_next,
  output logic               core_mode,
  output logic [511:0]       core_key,
  output logic [BLOCK_W-1:0] core_block,
  input  logic               core_ready,
  input  logic               core_tag_valid,
  input  logic [511:0]       core_tag
);
  state_e state_q, state_d, pend_q, last_nx;
  logic mode_q, first_q, final_q, mark_q;
  logic [511:0] key_q, tag_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0] wptr_q, markp_q;
  logic hs, fire, tag_in;
  logic buf_clr, buf_we, buf_len_we;
  logic [4:0] buf_addr;
  logic [31:0] buf_data;
  logic [3:0] buf_mask;
  assign hs = msg_valid && state_q == FILL;
  assign fire = state_q == ISSUE && core_ready;
  assign tag_in = state_q == WAIT && core_tag_valid;
  // A full last word defers its pad byte to the next word (possibly of the next block)
  assign last_nx = (msg_bytes < 3'd4) ? (wptr_q < 5'(LEN_WORD) ? LEN : PAD)
                 : (wptr_q == 5'd31) ? ISSUE
                 : (wptr_q < 5'(LEN_WORD - 1)) ? LEN : PAD;
  assign core_mode = mode_q;
  assign core_key = key_q;
  assign tag = tag_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else state_q <= zeroize ? IDLE : state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? FILL : IDLE;
      FILL:    state_d = !hs ? FILL : msg_last ? last_nx : (wptr_q == 5'd31 ? ISSUE : FILL);
      PAD:     state_d = ISSUE;
      LEN:     state_d = ISSUE;
      ISSUE:   state_d = core_ready ? WAIT : ISSUE;
      WAIT:    state_d = !core_tag_valid ? WAIT : final_q ? DONE : pend_q;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    msg_ready = state_q == FILL;
    busy = state_q != IDLE && state_q != DONE;
    tag_valid = state_q == DONE;
    core_init = fire && first_q;
    core_next = fire && !first_q;
    buf_clr = zeroize || (state_q == IDLE && start) || (tag_in && !final_q);
    buf_we = hs || ((state_q == PAD || state_q == LEN) && mark_q);
    buf_addr = hs ? wptr_q : markp_q;
    buf_data = hs ? (msg_last ? pad_word(msg_data, msg_bytes) : msg_data) : {PAD_BYTE, 24'h0};
    buf_mask = hs ? ~(4'b0111 >> msg_bytes) : 4'hF;
    buf_len_we = state_q == LEN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= 1'b0;
      key_q <= '0;
      tag_q <= '0;
      cnt_q <= '0;
      wptr_q <= '0;
      markp_q <= '0;
      first_q <= 1'b0;
      final_q <= 1'b0;
      mark_q <= 1'b0;
      pend_q <= IDLE;
    end else if (zeroize) begin
      mode_q <= 1'b0;
      key_q <= '0;
      tag_q <= '0;
      cnt_q <= '0;
      wptr_q <= '0;
      markp_q <= '0;
      first_q <= 1'b0;
      final_q <= 1'b0;
      mark_q <= 1'b0;
      pend_q <= IDLE;
    end else begin
      if (state_q == IDLE && start) begin
        mode_q <= mode;
        key_q <= key;
        tag_q <= '0;
        cnt_q <= '0;
        wptr_q <= '0;
        first_q <= 1'b1;
        final_q <= 1'b0;
        mark_q <= 1'b0;
      end
      if (hs) begin
        cnt_q <= cnt_q + CNT_W'(msg_bytes);
        wptr_q <= wptr_q + 5'd1;
        pend_q <= msg_last ? LEN : FILL;
        if (msg_last && msg_bytes > 3'd3) begin
          mark_q <= 1'b1;
          markp_q <= wptr_q + 5'd1;
        end
      end
      if (state_q == PAD) begin
        mark_q <= 1'b0;
        pend_q <= LEN;
      end
      if (state_q == LEN) begin
        mark_q <= 1'b0;
        final_q <= 1'b1;
      end
      if (fire) first_q <= 1'b0;
      if (tag_in && final_q) tag_q <= core_tag;
      if (tag_in && !final_q) wptr_q <= '0;
    end
  end

  hmac_blk_buf u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (buf_clr),
    .we_i     (buf_we),
    .waddr_i  (buf_addr),
    .wdata_i  (buf_data),
    .wmask_i  (buf_mask),
    .len_we_i (buf_len_we),
    .len_i    ({cnt_q[CNT_W-4:0], 3'b000} + CNT_W'(KEY_BLK_BITS)),
    .rdata_o  (core_block)
  );
endmodule

// File: tb/tb_hmac_msg_sequencer.sv
// tb_hmac_msg_sequencer: randomized message runs checked against a byte-level SHA-512 padding model
module tb_hmac_msg_sequencer;
  logic clk = 1'b0, reset_n = 1'b0, zeroize = 1'b0, start = 1'b0, mode = 1'b0;
  logic [511:0] key = '0, core_tag = '0;
  logic msg_valid = 1'b0, msg_last = 1'b0, core_ready = 1'b0, core_tag_valid = 1'b0;
  logic [31:0] msg_data = '0;
  logic [2:0] msg_bytes = '0;
  logic msg_ready, busy, tag_valid, core_init, core_next, core_mode;
  logic [511:0] tag, core_key;
  logic [1023:0] core_block, blk0_seen;
  int checks = 0, errors = 0, blocks_seen = 0;

  always #5 clk = ~clk;

  hmac_msg_sequencer dut (
    .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .start(start), .mode(mode), .key(key),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data), .msg_last(msg_last),
    .msg_bytes(msg_bytes), .busy(busy), .tag(tag), .tag_valid(tag_valid), .core_init(core_init),
    .core_next(core_next), .core_mode(core_mode), .core_key(core_key), .core_block(core_block),
    .core_ready(core_ready), .core_tag_valid(core_tag_valid), .core_tag(core_tag)
  );

  task automatic chk1(input string name, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin errors++; $error("FAIL %s observed=%b expected=%b", name, obs, exp); end
  endtask

  task automatic chki(input string name, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin errors++; $error("FAIL %s observed=%0d expected=%0d", name, obs, exp); end
  endtask

  task automatic chkw(input string name, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", name, obs, exp); end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Sends an n-byte message and plays the core; abort zeroizes during the first block's wait
  task automatic run_msg(input int n, input bit md, input int vprob, input int rdelay,
                         input bit abort, input bit fx, input logic [31:0] fw);
    logic [31:0] w[$];
    int wb[$];
    byte unsigned q[$];
    logic [1023:0] exp_b[$];
    logic [1023:0] held, bb;
    logic [511:0] k, ctag;
    logic [63:0] len;
    logic [31:0] tmp;
    int nw, wi, blk, cyc, rd, wt;
    bit done, tv_due, ab_due, sent_final, sent_abort;
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      w.push_back(fx ? fw : $urandom);
      wb.push_back((i == nw - 1) ? n - 4 * i : 4);
    end
    for (int i = 0; i < nw; i++) begin
      tmp = w[i];
      for (int j = 0; j < wb[i]; j++) q.push_back(tmp[31 - 8*j -: 8]);
    end
    q.push_back(8'h80);
    while (q.size() % 128 != 112) q.push_back(8'h00);
    len = 64'(n) * 64'd8 + 64'd1024;
    for (int j = 0; j < 8; j++) q.push_back(8'h00);
    for (int j = 7; j >= 0; j--) q.push_back(len[8*j +: 8]);
    for (int b = 0; b < q.size() / 128; b++) begin
      for (int j = 0; j < 128; j++) bb[1023 - 8*j -: 8] = q[128*b + j];
      exp_b.push_back(bb);
    end
    k = rnd512();
    ctag = '0;
    held = '0;
    @(negedge clk);
    start = 1'b1; mode = md; key = k;
    @(negedge clk);
    start = 1'b0; mode = ~md; key = ~k;
    #1;
    chk1("busy_after_start", busy, 1'b1);
    chk1("core_mode", core_mode, md);
    chkw("core_key", core_key, k);
    wi = 0; blk = 0; cyc = 0; rd = rdelay; wt = -1;
    done = 0; tv_due = 0; ab_due = 0;
    while (!done && cyc < 4000) begin
      cyc++;
      core_tag_valid = 1'b0; zeroize = 1'b0; sent_final = 0; sent_abort = 0;
      if (wt == 0) begin
        if (abort && blk == 1) begin
          zeroize = 1'b1; sent_abort = 1;
        end else begin
          ctag = rnd512(); core_tag = ctag; core_tag_valid = 1'b1; sent_final = (blk == exp_b.size());
        end
      end
      msg_valid = (wi < nw) && ($urandom_range(99) < vprob);
      msg_data = msg_valid ? w[wi] : $urandom;
      msg_bytes = msg_valid ? 3'(wb[wi]) : 3'($urandom_range(7));
      msg_last = msg_valid ? (wi == nw - 1) : 1'($urandom_range(1));
      core_ready = (wt < 0) && (rd == 0);
      if (wt < 0 && rd > 0 && busy && !msg_ready) rd--;
      #1;
      if (tv_due) begin
        chk1("tag_valid_pulse", tag_valid, 1'b1);
        chkw("tag_value", tag, ctag);
        chk1("busy_done", busy, 1'b0);
        done = 1;
      end else chk1("tag_valid_quiet", tag_valid, 1'b0);
      if (ab_due) begin
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_ready", msg_ready, 1'b0);
        chkw("abort_tag", tag, '0);
        chkw("abort_key", core_key, '0);
        chkw("abort_block_hi", core_block[1023:512], '0);
        done = 1;
      end
      if (wt >= 0) begin
        chkw("hold_hi", core_block[1023:512], held[1023:512]);
        chkw("hold_lo", core_block[511:0], held[511:0]);
        chk1("ready_in_wait", msg_ready, 1'b0);
        chk1("no_cmd_in_wait", core_init | core_next, 1'b0);
      end
      if (core_init || core_next) begin
        chk1("cmd_is_init", core_init, blk == 0);
        chk1("cmd_one_hot", core_init & core_next, 1'b0);
        chk1("ready_in_issue", msg_ready, 1'b0);
        if (blk < exp_b.size()) begin
          bb = exp_b[blk];
          chkw("block_hi", core_block[1023:512], bb[1023:512]);
          chkw("block_lo", core_block[511:0], bb[511:0]);
        end else chki("extra_block", blk, exp_b.size());
        if (blk == 0) blk0_seen = core_block;
        held = core_block;
        blk++;
        wt = int'($urandom_range(5)) + 1;
      end
      if (msg_valid && msg_ready) wi++;
      tv_due = sent_final;
      ab_due = sent_abort;
      if (wt == 0) rd = rdelay;
      if (wt >= 0) wt--;
      @(negedge clk);
    end
    chk1("run_finished", done, 1'b1);
    blocks_seen = blk;
    msg_valid = 1'b0; core_tag_valid = 1'b0; zeroize = 1'b0;
    #1;
    if (!abort) begin
      chki("block_count", blk, exp_b.size());
      chki("words_taken", wi, nw);
      chk1("tag_valid_one_cycle", tag_valid, 1'b0);
      chkw("tag_held", tag, ctag);
    end
    chk1("idle_busy", busy, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", msg_ready, 1'b0);
    chk1("rst_tag_valid", tag_valid, 1'b0);
    chk1("rst_init", core_init, 1'b0);
    chk1("rst_next", core_next, 1'b0);
    chk1("rst_mode", core_mode, 1'b0);
    chkw("rst_key", core_key, '0);
    chkw("rst_tag", tag, '0);
    chkw("rst_block_hi", core_block[1023:512], '0);
    chkw("rst_block_lo", core_block[511:0], '0);
    reset_n = 1'b1;
    @(negedge clk);
    run_msg(0, 1'b1, 100, 0, 0, 0, 32'h0);
    chkw("empty_w0", 512'(blk0_seen[1023:992]), 512'(32'h80000000));
    chkw("empty_w31", 512'(blk0_seen[31:0]), 512'(32'h00000400));
    chki("empty_blocks", blocks_seen, 1);
    run_msg(3, 1'b0, 100, 0, 0, 1, 32'h61626300);
    chkw("abc_w0", 512'(blk0_seen[1023:992]), 512'(32'h61626380));
    chkw("abc_w31", 512'(blk0_seen[31:0]), 512'(32'h00000418));
    run_msg(111, 1'b1, 100, 0, 0, 0, 32'h0);
    chkw("b111_w31", 512'(blk0_seen[31:0]), 512'(32'h00000778));
    chkw("b111_w27_low", 512'(blk0_seen[1023-32*27-24 -: 8]), 512'(8'h80));
    run_msg(112, 1'b0, 100, 0, 0, 0, 32'h0);
    chki("b112_blocks", blocks_seen, 2);
    chkw("b112_w28", 512'(blk0_seen[1023-32*28 -: 32]), 512'(32'h80000000));
    chkw("b112_w31", 512'(blk0_seen[31:0]), '0);
    run_msg(300, 1'b1, 50, 10, 0, 0, 32'h0);
    chki("b300_blocks", blocks_seen, 3);
    run_msg(124, 1'b0, 70, 2, 0, 0, 32'h0);
    run_msg(128, 1'b1, 70, 2, 0, 0, 32'h0);
    run_msg(108, 1'b0, 100, 1, 0, 0, 32'h0);
    run_msg(200, 1'b1, 80, 3, 1, 0, 32'h0);
    run_msg(50, 1'b0, 90, 2, 0, 0, 32'h0);
    for (int r = 0; r < 10; r++)
      run_msg(int'($urandom_range(400)), 1'($urandom_range(1)), int'($urandom_range(100, 30)),
              int'($urandom_range(5)), 0, 0, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
